fifo_burst_reader: RTL and testbench

Read-side controller for the synchronous FIFO. It drains words in fixed-length bursts onto a valid/ready stream and marks the final word of each burst with a last flag. The block sits between the FIFO read port and a packet consumer, such as a DMA or serializer. A 2-entry output buffer absorbs the FIFO's 1-cycle read latency so that downstream backpressure never loses a word.

---
 rtl/fifo_rd_pkg.sv | 23 ++
 rtl/fifo_rd_skid.sv | 65 ++++++
 rtl/fifo_burst_reader.sv | 191 +++++++++++++++++++
 tb/tb_fifo_burst_reader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared types and constants for the FIFO burst reader.
// Holds the controller state encoding, ARM guard length and buffer depth.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    BURST,
    DRAIN
  } rd_state_e;

  // Cycles spent in ARM so RAM contents catch up with the count.
  localparam int ARM_CYCLES = 2;

  // Output buffer entries; absorbs the 1-cycle FIFO read latency.
  localparam int SKID_DEPTH = 2;

  // Bits needed for a counter holding 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 2-entry output buffer with valid/ready and occupancy.
// Slot 0 is always the head, so out_data_o is stable while stalled.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic [1:0]   occ_o
);

  localparam logic [1:0] FULL = 2'(SKID_DEPTH);

  logic [W-1:0] slot0_q, slot0_d;
  logic [W-1:0] slot1_q, slot1_d;
  logic [1:0]   occ_q, occ_d;
  logic         pop;
  logic         push;

  assign out_valid_o = occ_q != 2'd0;
  assign out_data_o  = slot0_q;
  assign occ_o       = occ_q;

  assign pop  = out_valid_o & out_ready_i;
  assign push = in_valid_i & ((occ_q != FULL) | pop);

  // Shift head on pop, then append the new word behind it.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    occ_d   = occ_q;
    if (pop) begin
      slot0_d = slot1_q;
      occ_d   = occ_q - 2'd1;
    end
    if (push) begin
      if (occ_d == 2'd0) begin
        slot0_d = in_data_i;
      end else begin
        slot1_d = in_data_i;
      end
      occ_d = occ_d + 2'd1;
    end
  end

  // Buffer storage and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot0_q <= '0;
      slot1_q <= '0;
      occ_q   <= '0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      occ_q   <= occ_d;
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains the FIFO in fixed bursts onto a stream.
// Define FIFO_RD_TIMEOUT_EN to flush partial bursts after TIMEOUT idle cycles.
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic                        fifoRdEn,
  input  logic [FIFO_WIDTH-1:0]       fifoRdData,
  input  logic                        fifoEmpty,
  input  logic [$clog2(FIFO_DEPTH):0] fifoDataCount,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [FIFO_WIDTH-1:0]       m_data,
  output logic                        m_last,
  output logic                        busy
);

  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam int IW = cnt_w(BURST_LEN);

  localparam logic [CW-1:0] FULL_CNT = CW'(BURST_LEN);
  localparam logic [IW-1:0] FULL_LEN = IW'(BURST_LEN);
  localparam logic [1:0]    ARM_END  = 2'(ARM_CYCLES - 1);

  rd_state_e state_q, state_d;

  logic [IW-1:0] issued_q, issued_d;
  logic          inflight_q, inflight_d;
  logic          last_fl_q, last_fl_d;
  logic [1:0]    arm_q, arm_d;

  logic [IW-1:0] len;
  logic [IW-1:0] len_m1;
  logic          start;
  logic          timeout_hit;
  logic          burst_done;

  logic [1:0]    occ;
  logic          xfer;
  logic [2:0]    cap;
  logic [2:0]    used;
  logic          room;

  logic [FIFO_WIDTH:0] skid_data;

  assign xfer = m_valid & m_ready;
  assign cap  = 3'(SKID_DEPTH) + {2'b0, xfer};
  assign used = {1'b0, occ} + {2'b0, inflight_q};
  assign room = cap > used;

  assign len_m1     = len - IW'(1);
  assign start      = (fifoDataCount >= FULL_CNT) | timeout_hit;
  assign burst_done = issued_d == len;

`ifdef FIFO_RD_TIMEOUT_EN
  localparam int TW = cnt_w(TIMEOUT);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

  logic [TW-1:0] idle_q, idle_d;
  logic [CW-1:0] prev_cnt_q;
  logic [IW-1:0] len_q, len_d;
  logic          partial;
  logic          steady;

  assign partial = (fifoDataCount != '0) & (fifoDataCount < FULL_CNT);
  assign steady  = (state_q == IDLE) & partial
                 & (fifoDataCount == prev_cnt_q);
  assign timeout_hit = steady & (idle_q == TMO);
  assign len = len_q;

  // Idle timer restarts on any count change; latch the burst length.
  always_comb begin
    idle_d = '0;
    if (steady && idle_q != TMO) begin
      idle_d = idle_q + TW'(1);
    end
    len_d = len_q;
    if (state_q == IDLE) begin
      if (fifoDataCount >= FULL_CNT) begin
        len_d = FULL_LEN;
      end else if (timeout_hit) begin
        len_d = fifoDataCount[IW-1:0];
      end
    end
  end

  // Timeout state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_q     <= '0;
      prev_cnt_q <= '0;
      len_q      <= FULL_LEN;
    end else begin
      idle_q     <= idle_d;
      prev_cnt_q <= fifoDataCount;
      len_q      <= len_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign len         = FULL_LEN;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = ARM;
      end
      ARM: begin
        if (arm_q == ARM_END) state_d = BURST;
      end
      BURST: begin
        if (burst_done) state_d = DRAIN;
      end
      DRAIN: begin
        if (!m_valid && !inflight_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: pop only with buffer room left after the pending read.
  always_comb begin
    busy     = state_q != IDLE;
    fifoRdEn = (state_q == BURST) & ~fifoEmpty
             & (issued_q < len) & room;
  end

  // Issue counter, in-flight tag and ARM guard timer.
  always_comb begin
    issued_d = '0;
    if (state_q != IDLE) begin
      issued_d = issued_q + IW'(fifoRdEn);
    end
    inflight_d = fifoRdEn;
    last_fl_d  = fifoRdEn & (issued_q == len_m1);
    arm_d      = '0;
    if (state_q == ARM) begin
      arm_d = arm_q + 2'd1;
    end
  end

  // Datapath registers; reset drops any read still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      issued_q   <= '0;
      inflight_q <= 1'b0;
      last_fl_q  <= 1'b0;
      arm_q      <= '0;
    end else begin
      issued_q   <= issued_d;
      inflight_q <= inflight_d;
      last_fl_q  <= last_fl_d;
      arm_q      <= arm_d;
    end
  end

  fifo_rd_skid #(
    .W (FIFO_WIDTH + 1)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (inflight_q),
    .in_data_i   ({last_fl_q, fifoRdData}),
    .out_valid_o (m_valid),
    .out_ready_i (m_ready),
    .out_data_o  (skid_data),
    .occ_o       (occ)
  );

  assign m_data = skid_data[FIFO_WIDTH-1:0];
  assign m_last = skid_data[FIFO_WIDTH];

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed bench with a behavioural FIFO model.
// Build with FIFO_RD_TIMEOUT_EN to cover the partial-burst flush.
module tb_fifo_burst_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       fifoRdEn;
  logic [7:0] fifoRdData = '0;
  logic       fifoEmpty;
  logic [3:0] fifoDataCount;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic       busy;

  logic       wr_en;
  logic [7:0] wr_data;
  logic [7:0] mem [8];
  logic [2:0] wp  = '0;
  logic [2:0] rp  = '0;
  logic [3:0] cnt = '0;
  logic       do_wr;
  logic       do_rd;

  int errors = 0;
  int checks = 0;
  int pops;
  int idx;

  logic [10:0] e_rd   = 11'h078;
  logic [10:0] e_val  = 11'h1E0;
  logic [10:0] e_busy = 11'h3FE;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .FIFO_WIDTH (8),
    .FIFO_DEPTH (8),
    .BURST_LEN  (4),
    .TIMEOUT    (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fifoRdEn      (fifoRdEn),
    .fifoRdData    (fifoRdData),
    .fifoEmpty     (fifoEmpty),
    .fifoDataCount (fifoDataCount),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_last        (m_last),
    .busy          (busy)
  );

  assign fifoDataCount = cnt;
  assign fifoEmpty     = cnt == 4'd0;
  assign do_wr = wr_en && (cnt != 4'd8);
  assign do_rd = fifoRdEn && (cnt != 4'd0);

  always @(posedge clk) begin
    if (do_wr) begin
      mem[wp] <= wr_data;
      wp      <= wp + 3'd1;
    end
    if (do_rd) begin
      fifoRdData <= mem[rp];
      rp         <= rp + 3'd1;
    end
    cnt <= cnt + {3'b0, do_wr} - {3'b0, do_rd};
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic write_words(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + 8'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  task automatic recv(input logic [7:0] base, input int n,
                      input string tag);
    int got = 0;
    for (int c = 0; c < 200 && got < n; c++) begin
      if (m_valid) begin
        chk({tag, "_data"}, m_data, base + 8'(got));
        chk({tag, "_last"}, m_last, got == n - 1);
        got++;
      end
      if (got < n) @(negedge clk);
    end
    chk({tag, "_cnt"}, got, n);
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    while (busy && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk(tag, busy, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    m_ready = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_rden", fifoRdEn, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_last", m_last, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);

    m_ready = 1'b1;
    write_words(8'h11, 4);
    for (int c = 0; c < 11; c++) begin
      chk($sformatf("t1_rden_c%0d", c), fifoRdEn, e_rd[c]);
      chk($sformatf("t1_valid_c%0d", c), m_valid, e_val[c]);
      chk($sformatf("t1_busy_c%0d", c), busy, e_busy[c]);
      if (e_val[c]) begin
        chk("t1_data", m_data, 8'h11 + 8'(c - 5));
        chk("t1_last", m_last, c == 8);
      end
      @(negedge clk);
    end

    m_ready = 1'b0;
    idx = 0;
    for (int k = 0; k < 300 && idx < 8; k++) begin
      wr_en   = k < 8;
      wr_data = 8'h21 + 8'(k);
      if (m_valid) begin
        chk("t2_data", m_data, 8'h21 + 8'(idx));
        chk("t2_last", m_last, (idx % 4) == 3);
      end
      m_ready = ~m_ready;
      if (m_valid && m_ready) idx++;
      @(negedge clk);
    end
    wr_en = 1'b0;
    chk("t2_count", idx, 8);
    m_ready = 1'b1;
    wait_idle("t2_idle");
    chk("t2_fifo_empty", cnt, 0);
    chk("t2_no_extra", m_valid, 0);

    m_ready = 1'b0;
    write_words(8'h31, 4);
    pops = 0;
    repeat (20) begin
      pops += int'(fifoRdEn);
      @(negedge clk);
    end
    chk("t3_pops", pops, 2);
    chk("t3_fifo_cnt", cnt, 2);
    chk("t3_rden_low", fifoRdEn, 0);
    chk("t3_valid", m_valid, 1);
    m_ready = 1'b1;
    recv(8'h31, 4, "t3");
    wait_idle("t3_idle");

    write_words(8'h41, 4);
    repeat (6) @(negedge clk);
    chk("t4_word2_valid", m_valid, 1);
    chk("t4_word2_data", m_data, 8'h42);
    reset = 1'b1;
    @(negedge clk);
    chk("t4_rst_valid", m_valid, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_rden", fifoRdEn, 0);
    reset = 1'b0;
    chk("t4_fifo_cnt", cnt, 0);
    @(negedge clk);
    write_words(8'h51, 4);
    recv(8'h51, 4, "t4");
    wait_idle("t4_idle");

`ifdef FIFO_RD_TIMEOUT_EN
    write_words(8'hA0, 2);
    pops = 0;
    repeat (15) begin
      pops += int'(fifoRdEn);
      @(negedge clk);
    end
    chk("t5_early_pops", pops, 0);
    recv(8'hA0, 2, "t5");
    wait_idle("t5_idle");
`else
    write_words(8'hA0, 2);
    pops = 0;
    repeat (110) begin
      pops += int'(fifoRdEn);
      @(negedge clk);
    end
    chk("t6_pops", pops, 0);
    chk("t6_fifo_cnt", cnt, 2);
    chk("t6_busy", busy, 0);
    write_words(8'hA2, 2);
    recv(8'hA0, 4, "t6");
    wait_idle("t6_idle");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
